// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button conditioner pin/level/pulse bundle
interface btn_debounce_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_n_raw;
    logic [NUM_BTN-1:0] btn_n;
    logic [NUM_BTN-1:0] press;
    // "release" is a reserved word, hence the suffix
    logic [NUM_BTN-1:0] release_pulse;
    logic               any_press;

    modport master (
        input  btn_n_raw,
        output btn_n,
        output press,
        output release_pulse,
        output any_press
    );

    modport slave (
        output btn_n_raw,
        input  btn_n,
        input  press,
        input  release_pulse,
        input  any_press
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser and confirm-counter debouncer
module btn_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    btn_debounce_if.master  bus
);

    typedef enum logic [1:0] {REL, CONF_P, PRS, CONF_R} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] btn_n_q, btn_n_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic               any_press_q, any_press_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        btn_n_d   = '1;
        for (int i = 0; i < NUM_BTN; i++) begin
            case (state_q[i])
                REL: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = CONF_P;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                CONF_P: begin
                    if (sync2_q[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRS: begin
                    if (sync2_q[i]) begin
                        state_d[i] = CONF_R;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                CONF_R: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i]   = REL;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase
            // The clean level follows the accepted state, so it is registered alongside it
            btn_n_d[i] = (state_d[i] == REL) || (state_d[i] == CONF_P);
        end
        any_press_d = |press_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            btn_n_q     <= '1;
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= bus.btn_n_raw;
            sync2_q     <= sync1_q;
            btn_n_q     <= btn_n_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.btn_n         = btn_n_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.any_press     = any_press_q;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side conditioner for the board's active-low push buttons BTN1..BTN4.
- Synchronises each raw button to clk and debounces it with a per-button confirm counter.
- Outputs a clean active-low level for each button, plus one-cycle press and release pulses.
- Sits between the button pins and the LED state machines, so downstream FSMs react once per physical press.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronised samples required to accept a level change (10 ms at 12 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, confirm-counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- btn_n_raw  in  NUM_BTN  raw button pins, active-low (0 = pressed); asynchronous to clk.
- btn_n  out  NUM_BTN  debounced level, active-low, registered.
- press  out  NUM_BTN  one-cycle pulse when btn_n[i] goes 1->0.
- release  out  NUM_BTN  one-cycle pulse when btn_n[i] goes 0->1.
- any_press  out  1  OR of press[], registered in the same cycle as press.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - btn_n = all 1s; press, release and any_press = 0.
  - Both synchroniser stages reset to 1; every channel goes to REL with cnt=0.
  - All of the above takes effect immediately, including mid-confirm.
- Synchroniser: two flops per channel; s[i] is the second stage. FSM logic looks only at s[i].
- Per-channel FSM with four states: REL, CONF_P, PRS, CONF_R. Channels are fully independent.
  - REL: btn_n[i]=1. If s=0, go to CONF_P with cnt=1; otherwise stay.
  - CONF_P:
    - If s=1, return to REL with cnt=0; no pulse.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRS: btn_n[i] goes to 0 and press[i]=1 for exactly one cycle, cnt=0.
    - Else cnt+1.
  - PRS: btn_n[i]=0. If s=1, go to CONF_R with cnt=1.
  - CONF_R: mirror of CONF_P.
    - If s=0, return to PRS; no pulse.
    - On reaching DEBOUNCE_CYCLES-1, go to REL: btn_n[i] goes to 1 and release[i]=1 for one cycle.
- Latency: let edge k be the first edge whose synchroniser stage 1 captures the new raw level. If that level holds, btn_n and the pulse update at edge k+DEBOUNCE_CYCLES+1.
- A press is accepted only after exactly DEBOUNCE_CYCLES consecutive equal samples of s. Any single opposite sample restarts confirmation from the current stable state.
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is held at 0 in REL and PRS.
- Pulses:
  - press[i] and release[i] are never both high in the same cycle.
  - Pulses on different channels may coincide; any_press=1 if any press bit is high.
- Outputs are updated only by the FSM. Raw input never reaches outputs combinationally.
- Reset released while a button is held: the channel starts in REL and produces a normal press after DEBOUNCE_CYCLES+2 edges.

Test Plan:
(All with DEBOUNCE_CYCLES=4, NUM_BTN=4.)
- Reset: hold rst_n=0 with btn_n_raw=4'b0000 -> btn_n=4'b1111, press=0, release=0. Assert rst_n=0 asynchronously mid-cycle while in PRS -> btn_n returns to 1111 before the next edge.
- Clean press: btn_n_raw[0] goes 1->0 before edge k, then held -> btn_n[0]=0 and press[0]=1 after edge k+5, press[0]=0 after k+6; any_press mirrors press. Release the same way -> release[0] pulses at k'+5.
- Bounce: btn_n_raw[1] pattern 0,0,1,0,0,0,0 (one sample per edge) -> the single 1 restarts the count. Exactly one press[1] pulse, 4 stable samples after the bounce; no release pulse.
- Short glitch: btn_n_raw[2]=0 for 3 cycles, then 1 -> btn_n[2] stays 1; press and release stay 0 throughout.
- Simultaneous: btn_n_raw 1111->0000 on the same edge -> press=4'b1111 for one cycle and any_press=1 for one cycle. Then release only channel 3 -> release=4'b1000, and btn_n[2:0] stays 000.
- Held through reset: keep btn_n_raw[0]=0, pulse rst_n low for one cycle -> after deassert, btn_n[0]=1 for DEBOUNCE_CYCLES+1 edges, then one press[0] pulse.
